// File: rtl/rv64_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: mstatus bit positions,
// interrupt cause codes, mtvec modes and FSM states.
package rv64_trap_ctrl_pkg;

  localparam int XLEN = 64;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'b00,
    MTVEC_VECTORED = 2'b01
  } mtvec_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRAP_WR,
    ST_TRAP_JMP,
    ST_MRET_WR,
    ST_MRET_JMP
  } trap_state_e;

endpackage

// File: rtl/rv64_trap_ctrl_if.sv
// Commit-to-trap request channel: exception/mret valid with a shared ready.
interface rv64_trap_ctrl_if
  import rv64_trap_ctrl_pkg::*;
#(
  parameter int XLEN_P = XLEN
);
  logic              exc_valid;
  logic              exc_ready;
  logic [XLEN_P-1:0] exc_cause;
  logic [XLEN_P-1:0] exc_pc;
  logic [XLEN_P-1:0] exc_tval;
  logic              mret_valid;

  modport master (
    output exc_valid, exc_cause, exc_pc, exc_tval, mret_valid,
    input  exc_ready
  );

  modport slave (
    input  exc_valid, exc_cause, exc_pc, exc_tval, mret_valid,
    output exc_ready
  );
endinterface

// File: rtl/rv64_trap_vec_calc.sv
// Trap target from mtvec and cause. Vectored interrupt dispatch exists only
// when RV64_TRAP_IRQ_EN is defined; otherwise the target is always the base.
module rv64_trap_vec_calc
  import rv64_trap_ctrl_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  logic [XLEN_P-1:0] mtvec,
  input  logic [XLEN_P-1:0] cause,
  output logic [XLEN_P-1:0] target
);
  logic [XLEN_P-1:0] base;
  assign base = {mtvec[XLEN_P-1:2], 2'b00};

`ifdef RV64_TRAP_IRQ_EN
  // Reserved modes (1x) fall through to direct.
  always_comb begin
    target = base;
    if (mtvec[1:0] == MTVEC_VECTORED && cause[XLEN_P-1])
      target = base + {cause[XLEN_P-3:0], 2'b00};
  end
`else
  logic unused_vec;
  assign unused_vec = ^{mtvec[1:0], cause};
  assign target = base;
`endif
endmodule

// File: rtl/rv64_trap_ctrl.sv
// Machine-mode trap/mret sequencer driving per-CSR write ports and fetch redirect.
// Optional interrupt entry is enabled by defining RV64_TRAP_IRQ_EN.
module rv64_trap_ctrl
  import rv64_trap_ctrl_pkg::*;
#(
  parameter int         XLEN_P    = XLEN,
  parameter logic [1:0] MPP_RET_P = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  rv64_trap_ctrl_if.slave   exc,
  input  logic [XLEN_P-1:0] csr_mstatus_i,
  input  logic [XLEN_P-1:0] csr_mepc_i,
  input  logic [XLEN_P-1:0] csr_mtvec_i,
`ifdef RV64_TRAP_IRQ_EN
  input  logic              irq_mtip_i,
  input  logic              irq_msip_i,
  input  logic              irq_meip_i,
  input  logic [XLEN_P-1:0] csr_mie_i,
  input  logic              commit_bound_i,
`endif
  output logic [XLEN_P-1:0] csr_mstatus_o,
  output logic [XLEN_P-1:0] csr_mepc_o,
  output logic [XLEN_P-1:0] csr_mcause_o,
  output logic [XLEN_P-1:0] csr_mtval_o,
  output logic              csr_mstatus_en_o,
  output logic              csr_mepc_en_o,
  output logic              csr_mcause_en_o,
  output logic              csr_mtval_en_o,
  output logic              redirect_valid_o,
  output logic [XLEN_P-1:0] redirect_pc_o,
  output logic              busy_o
);

  trap_state_e       state;
  logic [XLEN_P-1:0] cause_q;
  logic [XLEN_P-1:0] vec_target;
  logic              trap_go;
  logic [XLEN_P-1:0] trap_cause;
  logic [XLEN_P-1:0] trap_tval;
  logic              unused_lo;

  assign unused_lo = ^{exc.exc_pc[1:0], csr_mepc_i[1:0]};

  function automatic logic [XLEN_P-1:0] trap_mstatus(input logic [XLEN_P-1:0] s);
    logic [XLEN_P-1:0] m;
    m = s;
    m[MSTATUS_MPIE] = s[MSTATUS_MIE];
    m[MSTATUS_MIE]  = 1'b0;
    m[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return m;
  endfunction

  function automatic logic [XLEN_P-1:0] mret_mstatus(input logic [XLEN_P-1:0] s);
    logic [XLEN_P-1:0] m;
    m = s;
    m[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    m[MSTATUS_MPIE] = 1'b1;
    m[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MPP_RET_P;
    return m;
  endfunction

`ifdef RV64_TRAP_IRQ_EN
  logic [2:0] irq_pend;
  logic [3:0] irq_code;
  logic       unused_irq;
  assign unused_irq = ^csr_mie_i;
`endif

  // Exception beats mret; a pending interrupt waits behind both and is re-evaluated in IDLE.
  always_comb begin
    trap_go    = exc.exc_valid;
    trap_cause = exc.exc_cause;
    trap_tval  = exc.exc_tval;
`ifdef RV64_TRAP_IRQ_EN
    irq_pend = {irq_meip_i & csr_mie_i[11], irq_msip_i & csr_mie_i[3], irq_mtip_i & csr_mie_i[7]};
    irq_code = irq_pend[2] ? IRQ_CODE_MEI : (irq_pend[1] ? IRQ_CODE_MSI : IRQ_CODE_MTI);
    if (!exc.exc_valid && !exc.mret_valid && commit_bound_i &&
        csr_mstatus_i[MSTATUS_MIE] && (|irq_pend)) begin
      trap_go    = 1'b1;
      trap_cause = '0;
      trap_cause[XLEN_P-1] = 1'b1;
      trap_cause[3:0]      = irq_code;
      trap_tval  = '0;
    end
`endif
  end

  rv64_trap_vec_calc #(.XLEN_P(XLEN_P)) u_vec_calc (
    .mtvec  (csr_mtvec_i),
    .cause  (cause_q),
    .target (vec_target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      cause_q          <= '0;
      exc.exc_ready    <= 1'b1;
      busy_o           <= 1'b0;
      csr_mstatus_o    <= '0;
      csr_mepc_o       <= '0;
      csr_mcause_o     <= '0;
      csr_mtval_o      <= '0;
      csr_mstatus_en_o <= 1'b0;
      csr_mepc_en_o    <= 1'b0;
      csr_mcause_en_o  <= 1'b0;
      csr_mtval_en_o   <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      csr_mstatus_o    <= '0;
      csr_mepc_o       <= '0;
      csr_mcause_o     <= '0;
      csr_mtval_o      <= '0;
      csr_mstatus_en_o <= 1'b0;
      csr_mepc_en_o    <= 1'b0;
      csr_mcause_en_o  <= 1'b0;
      csr_mtval_en_o   <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      unique case (state)
        ST_IDLE: begin
          if (trap_go) begin
            state            <= ST_TRAP_WR;
            cause_q          <= trap_cause;
            exc.exc_ready    <= 1'b0;
            busy_o           <= 1'b1;
            csr_mstatus_o    <= trap_mstatus(csr_mstatus_i);
            csr_mepc_o       <= {exc.exc_pc[XLEN_P-1:2], 2'b00};
            csr_mcause_o     <= trap_cause;
            csr_mtval_o      <= trap_tval;
            csr_mstatus_en_o <= 1'b1;
            csr_mepc_en_o    <= 1'b1;
            csr_mcause_en_o  <= 1'b1;
            csr_mtval_en_o   <= 1'b1;
          end else if (exc.mret_valid) begin
            state            <= ST_MRET_WR;
            exc.exc_ready    <= 1'b0;
            busy_o           <= 1'b1;
            csr_mstatus_o    <= mret_mstatus(csr_mstatus_i);
            csr_mstatus_en_o <= 1'b1;
          end
        end
        ST_TRAP_WR: begin
          state            <= ST_TRAP_JMP;
          redirect_valid_o <= 1'b1;
          redirect_pc_o    <= vec_target;
        end
        ST_MRET_WR: begin
          state            <= ST_MRET_JMP;
          redirect_valid_o <= 1'b1;
          redirect_pc_o    <= {csr_mepc_i[XLEN_P-1:2], 2'b00};
        end
        ST_TRAP_JMP, ST_MRET_JMP: begin
          state         <= ST_IDLE;
          exc.exc_ready <= 1'b1;
          busy_o        <= 1'b0;
        end
        default: begin
          state         <= ST_IDLE;
          exc.exc_ready <= 1'b1;
          busy_o        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv64_trap_ctrl.sv
// Scoreboard bench for rv64_trap_ctrl: expected CSR-write/redirect beats are queued
// when a request is driven and compared, with latency, as the DUT emits them.
module tb_rv64_trap_ctrl;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rv64_trap_ctrl_if #(.XLEN_P(W)) exc_if ();

  logic [W-1:0] mstatus_i, mepc_i, mtvec_i;
  logic [W-1:0] mstatus_o, mepc_o, mcause_o, mtval_o, redirect_pc;
  logic         mstatus_en, mepc_en, mcause_en, mtval_en, redirect_valid, busy;
`ifdef RV64_TRAP_IRQ_EN
  logic         mtip, msip, meip, commit_bound;
  logic [W-1:0] mie;
`endif

  rv64_trap_ctrl #(.XLEN_P(W), .MPP_RET_P(2'b11)) dut (
    .clk              (clk),
    .rst              (rst),
    .exc              (exc_if),
    .csr_mstatus_i    (mstatus_i),
    .csr_mepc_i       (mepc_i),
    .csr_mtvec_i      (mtvec_i),
`ifdef RV64_TRAP_IRQ_EN
    .irq_mtip_i       (mtip),
    .irq_msip_i       (msip),
    .irq_meip_i       (meip),
    .csr_mie_i        (mie),
    .commit_bound_i   (commit_bound),
`endif
    .csr_mstatus_o    (mstatus_o),
    .csr_mepc_o       (mepc_o),
    .csr_mcause_o     (mcause_o),
    .csr_mtval_o      (mtval_o),
    .csr_mstatus_en_o (mstatus_en),
    .csr_mepc_en_o    (mepc_en),
    .csr_mcause_en_o  (mcause_en),
    .csr_mtval_en_o   (mtval_en),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .busy_o           (busy)
  );

  typedef struct packed {
    logic [3:0]   en;   // {mstatus, mepc, mcause, mtval}
    logic         rdy;
    logic         busy;
    logic         rv;
    logic [W-1:0] rpc;
    logic [W-1:0] mst;
    logic [W-1:0] mepc;
    logic [W-1:0] mcause;
    logic [W-1:0] mtval;
    logic [7:0]   lat;
  } beat_t;

  beat_t sb[$];
  int unsigned checks = 0;
  int unsigned passes = 0;

  // Data fields are only meaningful while their strobe is high.
  function automatic beat_t sample();
    beat_t o;
    o.en     = {mstatus_en, mepc_en, mcause_en, mtval_en};
    o.rdy    = exc_if.exc_ready;
    o.busy   = busy;
    o.rv     = redirect_valid;
    o.rpc    = redirect_valid ? redirect_pc : '0;
    o.mst    = mstatus_en ? mstatus_o : '0;
    o.mepc   = mepc_en ? mepc_o : '0;
    o.mcause = mcause_en ? mcause_o : '0;
    o.mtval  = mtval_en ? mtval_o : '0;
    o.lat    = 8'(cyc - acc_cyc);
    return o;
  endfunction

  function automatic beat_t mk(logic [3:0] en, logic rv, logic [W-1:0] rpc, logic [W-1:0] mst,
                               logic [W-1:0] mepc, logic [W-1:0] mcause, logic [W-1:0] mtval,
                               logic [7:0] lat);
    beat_t b;
    b.en = en; b.rdy = 1'b0; b.busy = 1'b1; b.rv = rv; b.rpc = rpc;
    b.mst = mst; b.mepc = mepc; b.mcause = mcause; b.mtval = mtval; b.lat = lat;
    return b;
  endfunction

  function automatic string fmt(beat_t b);
    return $sformatf("en=%b rdy=%b busy=%b rv=%b rpc=%h mst=%h mepc=%h mcause=%h mtval=%h lat=%0d",
                     b.en, b.rdy, b.busy, b.rv, b.rpc, b.mst, b.mepc, b.mcause, b.mtval, b.lat);
  endfunction

  task automatic wait_out(output beat_t o, output bit ok);
    ok = 1'b0;
    o  = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      o = sample();
      if (o.en != 4'b0 || o.rv) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive_req(input logic ev, input logic mv, input logic [W-1:0] cause,
                           input logic [W-1:0] pc, input logic [W-1:0] tval);
    @(negedge clk);
    exc_if.exc_valid  = ev;
    exc_if.mret_valid = mv;
    exc_if.exc_cause  = cause;
    exc_if.exc_pc     = pc;
    exc_if.exc_tval   = tval;
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    exc_if.exc_valid  = 1'b0;
    exc_if.mret_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (exc_if.exc_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", exc_if.exc_ready);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy);
    else passes++;
    checks++;
    if ({mstatus_en, mepc_en, mcause_en, mtval_en, redirect_valid} !== 5'b0)
      $display("FAIL reset_strobes got=%b exp=00000",
               {mstatus_en, mepc_en, mcause_en, mtval_en, redirect_valid});
    else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_trap();
    beat_t o, e;
    bit ok;
    mstatus_i = 64'h8; mtvec_i = 64'h8000_1000; mepc_i = '0;
    sb.push_back(mk(4'hf, 1'b0, '0, 64'h1880, 64'h8000_0104, 64'd2, 64'hDEAD, 8'd1));
    sb.push_back(mk(4'h0, 1'b1, 64'h8000_1000, '0, '0, '0, '0, 8'd2));
    drive_req(1'b1, 1'b0, 64'd2, 64'h8000_0104, 64'hDEAD);
    for (int i = 0; i < 2; i++) begin
      wait_out(o, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || o !== e) $display("FAIL trap[%0d] got: %s exp: %s", i, fmt(o), fmt(e));
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (exc_if.exc_ready !== 1'b1 || busy !== 1'b0 || cyc - acc_cyc != 3)
      $display("FAIL trap_ready_again got rdy=%b busy=%b lat=%0d exp rdy=1 busy=0 lat=3",
               exc_if.exc_ready, busy, cyc - acc_cyc);
    else passes++;
  endtask

  task automatic test_mret();
    beat_t o, e;
    bit ok;
    mstatus_i = 64'h1880; mepc_i = 64'h8000_0108;
    sb.push_back(mk(4'b1000, 1'b0, '0, 64'h1888, '0, '0, '0, 8'd1));
    sb.push_back(mk(4'h0, 1'b1, 64'h8000_0108, '0, '0, '0, '0, 8'd2));
    drive_req(1'b0, 1'b1, '0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      wait_out(o, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || o !== e) $display("FAIL mret[%0d] got: %s exp: %s", i, fmt(o), fmt(e));
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (exc_if.exc_ready !== 1'b1 || cyc - acc_cyc != 3)
      $display("FAIL mret_ready_again got rdy=%b lat=%0d exp rdy=1 lat=3",
               exc_if.exc_ready, cyc - acc_cyc);
    else passes++;
  endtask

  task automatic test_simultaneous();
    beat_t o, e;
    bit ok;
    mstatus_i = 64'h0; mtvec_i = 64'h8000_1000; mepc_i = 64'h8000_0500;
    sb.push_back(mk(4'hf, 1'b0, '0, 64'h1800, 64'h8000_0200, 64'd5, 64'h11, 8'd1));
    sb.push_back(mk(4'h0, 1'b1, 64'h8000_1000, '0, '0, '0, '0, 8'd2));
    drive_req(1'b1, 1'b1, 64'd5, 64'h8000_0200, 64'h11);
    for (int i = 0; i < 2; i++) begin
      wait_out(o, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || o !== e) $display("FAIL simul[%0d] got: %s exp: %s", i, fmt(o), fmt(e));
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (exc_if.exc_ready !== 1'b1 || mstatus_en !== 1'b0)
      $display("FAIL simul_after got rdy=%b mstatus_en=%b exp rdy=1 mstatus_en=0",
               exc_if.exc_ready, mstatus_en);
    else passes++;
  endtask

  task automatic test_reset_mid();
    bit bad;
    mstatus_i = 64'h8; mtvec_i = 64'h8000_1000;
    drive_req(1'b1, 1'b0, 64'd3, 64'h8000_0300, 64'h0);
    @(negedge clk);
    checks++;
    if ({mstatus_en, mepc_en, mcause_en, mtval_en} !== 4'hf)
      $display("FAIL rstmid_in_wr got=%b exp=1111", {mstatus_en, mepc_en, mcause_en, mtval_en});
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mstatus_en, mepc_en, mcause_en, mtval_en, redirect_valid} !== 5'b0 ||
        exc_if.exc_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rstmid_clear got en=%b rv=%b rdy=%b busy=%b exp en=0000 rv=0 rdy=1 busy=0",
               {mstatus_en, mepc_en, mcause_en, mtval_en}, redirect_valid, exc_if.exc_ready, busy);
    else passes++;
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ({mstatus_en, mepc_en, mcause_en, mtval_en, redirect_valid} !== 5'b0 ||
          exc_if.exc_ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL rstmid_quiet got late strobe/redirect or rdy=0 exp none");
    else passes++;
  endtask

  task automatic test_back_to_back();
    beat_t o, e;
    bit ok;
    mstatus_i = 64'h8; mtvec_i = 64'h8000_1003;
    sb.push_back(mk(4'hf, 1'b0, '0, 64'h1880, 64'h8000_0300, 64'd4, 64'h44, 8'd1));
    sb.push_back(mk(4'h0, 1'b1, 64'h8000_1000, '0, '0, '0, '0, 8'd2));
    sb.push_back(mk(4'hf, 1'b0, '0, 64'h1880, 64'h8000_0304, 64'd6, 64'h66, 8'd4));
    sb.push_back(mk(4'h0, 1'b1, 64'h8000_1000, '0, '0, '0, '0, 8'd5));
    fork
      begin
        @(negedge clk);
        exc_if.exc_valid = 1'b1;
        exc_if.exc_cause = 64'd4; exc_if.exc_pc = 64'h8000_0300; exc_if.exc_tval = 64'h44;
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        exc_if.exc_cause = 64'd6; exc_if.exc_pc = 64'h8000_0307; exc_if.exc_tval = 64'h66;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (exc_if.exc_ready) begin
            @(posedge clk);
            #1 exc_if.exc_valid = 1'b0;
            break;
          end
        end
        exc_if.exc_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          wait_out(o, ok);
          e = sb.pop_front();
          checks++;
          if (!ok || o !== e) $display("FAIL b2b[%0d] got: %s exp: %s", i, fmt(o), fmt(e));
          else passes++;
        end
      end
    join
    repeat (2) @(negedge clk);
  endtask

`ifdef RV64_TRAP_IRQ_EN
  task automatic test_irq();
    beat_t o, e;
    bit ok;
    mstatus_i = 64'h8; mtvec_i = 64'h8000_1001; mie = 64'h80;
    sb.push_back(mk(4'hf, 1'b0, '0, 64'h1880, 64'h8000_0400, 64'h8000_0000_0000_0007, '0, 8'd1));
    sb.push_back(mk(4'h0, 1'b1, 64'h8000_101C, '0, '0, '0, '0, 8'd2));
    @(negedge clk);
    mtip = 1'b1; commit_bound = 1'b1; exc_if.exc_pc = 64'h8000_0400;
    acc_cyc = cyc;
    @(posedge clk);
    #1 commit_bound = 1'b0; mtip = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_out(o, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || o !== e) $display("FAIL irq[%0d] got: %s exp: %s", i, fmt(o), fmt(e));
      else passes++;
    end
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1);
  end

  initial begin
    exc_if.exc_valid = 1'b0; exc_if.mret_valid = 1'b0;
    exc_if.exc_cause = '0; exc_if.exc_pc = '0; exc_if.exc_tval = '0;
    mstatus_i = '0; mepc_i = '0; mtvec_i = '0;
`ifdef RV64_TRAP_IRQ_EN
    mtip = 1'b0; msip = 1'b0; meip = 1'b0; commit_bound = 1'b0; mie = '0;
`endif
    test_reset();
    test_trap();
    test_mret();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
`ifdef RV64_TRAP_IRQ_EN
    test_irq();
`endif
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0 entries left", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
